// File: rtl/jtvigil_palsched.sv
// Palette RAM slot scheduler: three colour reads per pixel plus one CPU slot,
// with every slot handed to the CPU while the sampled pixel is blanked.
module jtvigil_palsched #(
    parameter bit BLANK_CPU = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pxl_cen,
    input  logic        LHBL,
    input  logic        LVBL,
    input  logic        pxl_sel,
    input  logic [7:0]  pxl_base,
    input  logic        cpu_req,
    input  logic        cpu_rnw,
    input  logic [10:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        cpu_ok,
    output logic [10:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    input  logic [7:0]  ram_dout,
    output logic [4:0]  red,
    output logic [4:0]  green,
    output logic [4:0]  blue,
    output logic [1:0]  o_dbg_state
);

    // CPU handshake: cpu_req is a level held until cpu_ok; cpu_ok is a one-cycle
    // pulse in DONE, where cpu_din is valid for reads. DONE ignores cpu_req.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_sub;
    logic [2:0]  w_sub_nxt;
    logic [8:0]  r_idx;
    logic [8:0]  w_idx_nxt;
    logic        r_blank;
    logic        w_blank_nxt;
    logic        w_fetch;
    logic        w_slot;
    logic        w_grant;
    logic [1:0]  w_chan;
    logic        r_fetch_cur;
    logic        r_fetch_prev;
    logic [4:0]  r_cap_r;
    logic [4:0]  r_cap_g;
    logic [4:0]  r_cap_b;
    logic        r_rnw;
    logic [7:0]  r_cpu_din;

    // Decisions look at the sub/pixel state of the next cycle so that the
    // registered RAM controls land exactly in the slot they belong to.
    always_comb begin
        w_sub_nxt   = pxl_cen ? 3'd1 : r_sub + 3'd1;
        w_idx_nxt   = pxl_cen ? {pxl_sel, pxl_base} : r_idx;
        w_blank_nxt = pxl_cen ? (!LHBL || !LVBL) : r_blank;
        w_fetch     = (!w_blank_nxt || !BLANK_CPU) && (w_sub_nxt >= 3'd1) && (w_sub_nxt <= 3'd3);
        w_chan      = w_sub_nxt[1:0] - 2'd1;
        w_slot      = !w_fetch && ((w_blank_nxt && BLANK_CPU) || (w_sub_nxt == 3'd5));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (cpu_req && w_slot) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_DONE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_grant     = (r_state == ST_IDLE) && cpu_req && w_slot;
        cpu_ok      = (r_state == ST_DONE);
        cpu_din     = ((r_state == ST_DONE) && r_rnw) ? ram_dout : r_cpu_din;
        o_dbg_state = r_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sub        <= 3'd0;
            r_idx        <= 9'd0;
            r_blank      <= 1'b0;
            r_fetch_cur  <= 1'b0;
            r_fetch_prev <= 1'b0;
            r_cap_r      <= 5'd0;
            r_cap_g      <= 5'd0;
            r_cap_b      <= 5'd0;
            red          <= 5'd0;
            green        <= 5'd0;
            blue         <= 5'd0;
            ram_addr     <= 11'd0;
            ram_din      <= 8'd0;
            ram_we       <= 1'b0;
            r_rnw        <= 1'b0;
            r_cpu_din    <= 8'd0;
        end else begin
            r_sub        <= w_sub_nxt;
            r_idx        <= w_idx_nxt;
            r_blank      <= w_blank_nxt;
            r_fetch_cur  <= w_fetch;
            r_fetch_prev <= r_fetch_cur;
            if (pxl_cen) begin
                red   <= r_blank ? 5'd0 : r_cap_r;
                green <= r_blank ? 5'd0 : r_cap_g;
                blue  <= r_blank ? 5'd0 : r_cap_b;
            end
            // Capture only data that a fetch actually addressed; an aborted
            // fetch leaves the remaining channels stale.
            if (r_fetch_prev) begin
                case (r_sub)
                    3'd2:    r_cap_r <= ram_dout[4:0];
                    3'd3:    r_cap_g <= ram_dout[4:0];
                    3'd4:    r_cap_b <= ram_dout[4:0];
                    default: ;
                endcase
            end
            ram_we <= 1'b0;
            if (w_fetch) begin
                ram_addr <= {w_idx_nxt[8], w_chan, w_idx_nxt[7:0]};
            end else if (w_grant) begin
                ram_addr <= cpu_addr;
                ram_din  <= cpu_dout;
                ram_we   <= !cpu_rnw;
                r_rnw    <= cpu_rnw;
            end
            if ((r_state == ST_DONE) && r_rnw) r_cpu_din <= ram_dout;
        end
    end

endmodule

// File: tb/tb_jtvigil_palsched.sv
// Bench for jtvigil_palsched: palette RAM model, reference palette array and
// per-scenario tasks comparing colours and CPU slot timing.
module tb_jtvigil_palsched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pxl_cen = 1'b0;
    logic        LHBL = 1'b1;
    logic        LVBL = 1'b1;
    logic        pxl_sel = 1'b0;
    logic [7:0]  pxl_base = 8'd0;
    logic        cpu_req = 1'b0;
    logic        cpu_rnw = 1'b1;
    logic [10:0] cpu_addr = 11'd0;
    logic [7:0]  cpu_dout = 8'd0;
    logic [7:0]  cpu_din;
    logic        cpu_ok;
    logic [10:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic [7:0]  ram_dout;
    logic [4:0]  red, green, blue;
    logic [1:0]  dbg_state;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_seed = 32'd0;
    logic        mem_init = 1'b0;
    logic [7:0]  ram_mem [2048];
    logic [7:0]  ref_mem [2048];
    logic [14:0] exp_q [$];

    jtvigil_palsched dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
        .pxl_sel(pxl_sel), .pxl_base(pxl_base), .cpu_req(cpu_req), .cpu_rnw(cpu_rnw),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_ok(cpu_ok),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .red(red), .green(green), .blue(blue), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int a);
        logic [31:0] h;
        if (a == 'h000) return 8'h11;
        if (a == 'h100) return 8'h12;
        if (a == 'h200) return 8'h13;
        h = a * 32'h9E3779B1 + mem_seed;
        return h[23:16];
    endfunction

    // Single-port palette RAM: read data one clock after the address.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 2048; i++) ram_mem[i] <= init_val(i);
        end else if (ram_we) begin
            ram_mem[ram_addr] <= ram_din;
        end
        ram_dout <= ram_mem[ram_addr];
    end

    function automatic logic [14:0] exp_col(input logic sel, input logic [7:0] base, input logic blank);
        if (blank) return 15'd0;
        return {ref_mem[{sel, 2'b00, base}][4:0], ref_mem[{sel, 2'b01, base}][4:0],
                ref_mem[{sel, 2'b10, base}][4:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pixel(input logic sel, input logic [7:0] base, input logic lh, input logic lv);
        pxl_sel  = sel;
        pxl_base = base;
        LHBL     = lh;
        LVBL     = lv;
        pxl_cen  = 1'b1;
        tick();
        pxl_cen  = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++; if ({red, green, blue} !== 15'd0) begin errors++; $display("FAIL reset_rgb: got %h expected 0", {red, green, blue}); end
        checks++; if (cpu_ok !== 1'b0) begin errors++; $display("FAIL reset_ok: got %b expected 0", cpu_ok); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", ram_we); end
        checks++; if (ram_addr !== 11'd0) begin errors++; $display("FAIL reset_addr: got %h expected 0", ram_addr); end
        checks++; if (cpu_din !== 8'd0) begin errors++; $display("FAIL reset_din: got %h expected 0", cpu_din); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        logic        s, lh, lv;
        logic [7:0]  b;
        logic [14:0] got, exp;
        exp_q.push_back(exp_col(1'b0, 8'h00, 1'b0));
        start_pixel(1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            repeat (7) tick();
            s  = 1'($urandom_range(0, 1));
            b  = 8'($urandom_range(0, 255));
            lh = 1'b1;
            lv = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                lh = 1'b0;
                lv = 1'($urandom_range(0, 1));
            end
            exp_q.push_back(exp_col(s, b, !lh || !lv));
            start_pixel(s, b, lh, lv);
            got = {red, green, blue};
            exp = exp_q.pop_front();
            if (i == 0) begin
                checks++; if (got !== {5'h11, 5'h12, 5'h13}) begin errors++; $display("FAIL fetch_first: got %h expected %h", got, {5'h11, 5'h12, 5'h13}); end
            end
            checks++; if (got !== exp) begin errors++; $display("FAIL fetch_rand[%0d]: got %h expected %h", i, got, exp); end
        end
        exp_q.delete();
    endtask

    task automatic test_write();
        int          we_cnt = 0, we_k = 0, ok_k = 0;
        logic [10:0] we_addr = 11'd0;
        logic [7:0]  we_din = 8'd0;
        logic [14:0] exp;
        repeat (7) tick();
        cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_addr = 11'h405; cpu_dout = 8'h1F;
        start_pixel(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b1, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            if (ram_we) begin we_cnt++; we_k = k; we_addr = ram_addr; we_din = ram_din; end
            if (cpu_ok) begin ok_k = k; cpu_req = 1'b0; end
            tick();
        end
        cpu_req = 1'b0;
        checks++; if (we_cnt !== 1) begin errors++; $display("FAIL write_we_count: got %0d expected 1", we_cnt); end
        checks++; if (we_k !== 5) begin errors++; $display("FAIL write_we_sub: got %0d expected 5", we_k); end
        checks++; if (we_addr !== 11'h405) begin errors++; $display("FAIL write_addr: got %h expected 405", we_addr); end
        checks++; if (we_din !== 8'h1F) begin errors++; $display("FAIL write_data: got %h expected 1f", we_din); end
        checks++; if (ok_k !== 6) begin errors++; $display("FAIL write_ok_sub: got %0d expected 6", ok_k); end
        ref_mem[11'h405] = 8'h1F;
        exp = exp_col(1'b1, 8'h05, 1'b0);
        start_pixel(1'b1, 8'h05, 1'b1, 1'b1);
        repeat (7) tick();
        start_pixel(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b1, 1'b1);
        checks++; if (red !== 5'h1F) begin errors++; $display("FAIL write_readback_red: got %h expected 1f", red); end
        checks++; if ({red, green, blue} !== exp) begin errors++; $display("FAIL write_readback_rgb: got %h expected %h", {red, green, blue}, exp); end
    endtask

    task automatic test_blank_read();
        logic [10:0] a;
        a = 11'($urandom_range(0, 2047));
        repeat (7) tick();
        start_pixel(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b1, 1'b0);
        tick();
        cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = a;
        tick();
        checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL blank_issue_state: got %0d expected 1", dbg_state); end
        checks++; if (ram_addr !== a) begin errors++; $display("FAIL blank_issue_addr: got %h expected %h", ram_addr, a); end
        checks++; if ({ram_we, cpu_ok} !== 2'b00) begin errors++; $display("FAIL blank_issue_we_ok: got %b expected 00", {ram_we, cpu_ok}); end
        tick();
        checks++; if (cpu_ok !== 1'b1) begin errors++; $display("FAIL blank_ok: got %b expected 1", cpu_ok); end
        checks++; if (cpu_din !== ref_mem[a]) begin errors++; $display("FAIL blank_rdata: got %h expected %h", cpu_din, ref_mem[a]); end
        cpu_req = 1'b0;
        tick();
        checks++; if (cpu_ok !== 1'b0) begin errors++; $display("FAIL blank_ok_pulse: got %b expected 0", cpu_ok); end
        checks++; if (cpu_din !== ref_mem[a]) begin errors++; $display("FAIL blank_rdata_hold: got %h expected %h", cpu_din, ref_mem[a]); end
        repeat (3) tick();
        start_pixel(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b1, 1'b1);
        checks++; if ({red, green, blue} !== 15'd0) begin errors++; $display("FAIL blank_rgb_zero: got %h expected 0", {red, green, blue}); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] a1, a2;
        logic [7:0]  d1, d2;
        logic [10:0] wa [2];
        logic [7:0]  wd [2];
        logic [1:0]  st_k4 = 2'd3;
        int          we_cnt = 0, ok_cnt = 0, ok_k1 = 0, ok_k2 = 0;
        wa[0] = 11'd0; wa[1] = 11'd0; wd[0] = 8'd0; wd[1] = 8'd0;
        a1 = 11'($urandom_range(0, 2047));
        a2 = a1 ^ 11'h2A5;
        d1 = 8'($urandom_range(0, 255));
        d2 = 8'($urandom_range(0, 255));
        repeat (7) tick();
        start_pixel(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0, 1'b1);
        cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_addr = a1; cpu_dout = d1;
        for (int k = 1; k <= 7; k++) begin
            if (ram_we) begin
                if (we_cnt < 2) begin wa[we_cnt] = ram_addr; wd[we_cnt] = ram_din; end
                we_cnt++;
            end
            if (k == 4) st_k4 = dbg_state;
            if (cpu_ok) begin
                ok_cnt++;
                if (ok_cnt == 1) begin ok_k1 = k; cpu_addr = a2; cpu_dout = d2; end
                else begin ok_k2 = k; cpu_req = 1'b0; end
            end
            tick();
        end
        cpu_req = 1'b0;
        checks++; if (we_cnt !== 2) begin errors++; $display("FAIL b2b_we_count: got %0d expected 2", we_cnt); end
        checks++; if (ok_k1 !== 3) begin errors++; $display("FAIL b2b_ok1: got %0d expected 3", ok_k1); end
        checks++; if (st_k4 !== 2'd0) begin errors++; $display("FAIL b2b_idle_gap: got %0d expected 0", st_k4); end
        checks++; if (ok_k2 !== 6) begin errors++; $display("FAIL b2b_ok2: got %0d expected 6", ok_k2); end
        checks++; if ({wa[0], wd[0]} !== {a1, d1}) begin errors++; $display("FAIL b2b_first: got %h expected %h", {wa[0], wd[0]}, {a1, d1}); end
        checks++; if ({wa[1], wd[1]} !== {a2, d2}) begin errors++; $display("FAIL b2b_second: got %h expected %h", {wa[1], wd[1]}, {a2, d2}); end
        checks++; if ({ram_mem[a1], ram_mem[a2]} !== {d1, d2}) begin errors++; $display("FAIL b2b_ram: got %h expected %h", {ram_mem[a1], ram_mem[a2]}, {d1, d2}); end
        ref_mem[a1] = d1;
        ref_mem[a2] = d2;
        start_pixel(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b1, 1'b1);
    endtask

    task automatic test_early_pxl();
        logic        sa, sb;
        logic [7:0]  ba, bb, d3;
        logic [10:0] a3;
        logic [14:0] ea, eb, col_b;
        logic [10:0] addr_k [4];
        int          we_cnt = 0, we_k = 0, ok_k = 0;
        for (int i = 0; i < 4; i++) addr_k[i] = 11'd0;
        sa = 1'($urandom_range(0, 1)); ba = 8'($urandom_range(0, 255));
        sb = 1'($urandom_range(0, 1)); bb = 8'($urandom_range(0, 255));
        a3 = 11'($urandom_range(0, 2047)); d3 = 8'($urandom_range(0, 255));
        repeat (7) tick();
        ea = exp_col(sa, ba, 1'b0);
        start_pixel(sa, ba, 1'b1, 1'b1);
        repeat (5) tick();
        cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_addr = a3; cpu_dout = d3;
        eb = exp_col(sb, bb, 1'b0);
        start_pixel(sb, bb, 1'b1, 1'b1);
        col_b = {red, green, blue};
        for (int k = 1; k <= 7; k++) begin
            if (k <= 3) addr_k[k] = ram_addr;
            if (ram_we) begin we_cnt++; we_k = k; end
            if (cpu_ok) begin ok_k = k; cpu_req = 1'b0; end
            tick();
        end
        cpu_req = 1'b0;
        checks++; if (col_b !== ea) begin errors++; $display("FAIL early_prev_rgb: got %h expected %h", col_b, ea); end
        checks++; if (addr_k[1] !== {sb, 2'd0, bb}) begin errors++; $display("FAIL early_addr_r: got %h expected %h", addr_k[1], {sb, 2'd0, bb}); end
        checks++; if (addr_k[2] !== {sb, 2'd1, bb}) begin errors++; $display("FAIL early_addr_g: got %h expected %h", addr_k[2], {sb, 2'd1, bb}); end
        checks++; if (addr_k[3] !== {sb, 2'd2, bb}) begin errors++; $display("FAIL early_addr_b: got %h expected %h", addr_k[3], {sb, 2'd2, bb}); end
        checks++; if (we_cnt !== 1) begin errors++; $display("FAIL early_we_count: got %0d expected 1", we_cnt); end
        checks++; if (we_k !== 5) begin errors++; $display("FAIL early_we_sub: got %0d expected 5", we_k); end
        checks++; if (ok_k !== 6) begin errors++; $display("FAIL early_ok_sub: got %0d expected 6", ok_k); end
        checks++; if (ram_mem[a3] !== d3) begin errors++; $display("FAIL early_ram: got %h expected %h", ram_mem[a3], d3); end
        ref_mem[a3] = d3;
        start_pixel(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b1, 1'b1);
        checks++; if ({red, green, blue} !== eb) begin errors++; $display("FAIL early_rgb: got %h expected %h", {red, green, blue}, eb); end
    endtask

    task automatic test_reset_mid();
        int          ok_cnt = 0;
        logic [10:0] addr2 = 11'h7FF, addr3 = 11'h7FF;
        repeat (7) tick();
        start_pixel(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        cpu_req = 1'b1; cpu_rnw = 1'b0;
        cpu_addr = 11'($urandom_range(0, 2047)); cpu_dout = 8'($urandom_range(0, 255));
        tick();
        checks++; if ({dbg_state, ram_we} !== 3'b011) begin errors++; $display("FAIL rstmid_pre: got %b expected 011", {dbg_state, ram_we}); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({red, green, blue} !== 15'd0) begin errors++; $display("FAIL rstmid_rgb: got %h expected 0", {red, green, blue}); end
        checks++; if ({ram_we, cpu_ok, dbg_state} !== 4'd0) begin errors++; $display("FAIL rstmid_ctl: got %b expected 0000", {ram_we, cpu_ok, dbg_state}); end
        checks++; if ({ram_addr, ram_din, cpu_din} !== 27'd0) begin errors++; $display("FAIL rstmid_bus: got %h expected 0", {ram_addr, ram_din, cpu_din}); end
        cpu_req = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (cpu_ok) ok_cnt++;
            if (c == 2) addr2 = ram_addr;
            if (c == 3) addr3 = ram_addr;
        end
        checks++; if (ok_cnt !== 0) begin errors++; $display("FAIL rstmid_spurious_ok: got %0d expected 0", ok_cnt); end
        checks++; if (addr2 !== 11'h100) begin errors++; $display("FAIL rstmid_sub_align_g: got %h expected 100", addr2); end
        checks++; if (addr3 !== 11'h200) begin errors++; $display("FAIL rstmid_sub_align_b: got %h expected 200", addr3); end
    endtask

    initial begin
        mem_seed = $urandom;
        for (int i = 0; i < 2048; i++) ref_mem[i] = init_val(i);
        mem_init = 1'b1;
        tick();
        tick();
        mem_init = 1'b0;
        test_reset();
        test_fetch();
        test_write();
        test_blank_read();
        test_back_to_back();
        test_early_pxl();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
